mem_bus_if: RTL and testbench

MEM_BUS_IF -- requirements
Module: mem_bus_if

---
 rtl/mem_bus_if_pkg.sv | 12 +
 rtl/mem_bus_if_if.sv | 14 +
 rtl/mem_bus_if.sv | 112 +++++++++++
 tb/tb_mem_bus_if.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_if_pkg.sv
// mem_bus_if_pkg: shared FSM encodings, stall-vector index and control levels for the memory bus master.
package mem_bus_if_pkg;
   typedef enum logic [1:0] {
      IDLE           = 2'd0,
      BUSY           = 2'd1,
      WAIT_FOR_STALL = 2'd2
   } state_e;
   localparam int   STALL_MEM = 4;
   localparam logic Stop      = 1'b1;
   localparam logic NoStop    = 1'b0;
   localparam logic RstEnable = 1'b1;
endpackage

// File: rtl/mem_bus_if_if.sv
// mem_bus_if_if: single-beat bus between the memory-stage master and a slave.
interface mem_bus_if_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  sel;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        err;
   modport master (output cyc, stb, we, addr, sel, wdata, err, input rdata, ack);
   modport slave  (input cyc, stb, we, addr, sel, wdata, err, output rdata, ack);
endinterface

// File: rtl/mem_bus_if.sv
// mem_bus_if: memory-stage bus master with pipeline stall handshake, flush abort and ack timeout.
module mem_bus_if
   import mem_bus_if_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [5:0]   stall_i,
   input  logic         flush_i,
   input  logic         cpu_ce_i,
   input  logic         cpu_we_i,
   input  logic [31:0]  cpu_addr_i,
   input  logic [3:0]   cpu_sel_i,
   input  logic [31:0]  cpu_wdata_i,
   output logic [31:0]  cpu_rdata_o,
   output logic         stallreq_o,
   mem_bus_if_if.master bus
);
   localparam logic [15:0] cnt_last = 16'(TIMEOUT_CYCLES - 1);
   state_e      state_q, state_d;
   logic        cyc_q, cyc_d, we_q, we_d, err_q, err_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rd_buf_q, rd_buf_d;
   logic [3:0]  sel_q, sel_d;
   logic [15:0] cnt_q, cnt_d;
   logic        hold, ack_ok;
   assign hold   = |(stall_i & 6'(1 << STALL_MEM));
   assign ack_ok = bus.ack && !flush_i;
   assign bus.cyc   = cyc_q;
   assign bus.stb   = cyc_q;
   assign bus.we    = we_q;
   assign bus.addr  = addr_q;
   assign bus.sel   = sel_q;
   assign bus.wdata = wdata_q;
   assign bus.err   = err_q;
   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      addr_d      = addr_q;
      sel_d       = sel_q;
      wdata_d     = wdata_q;
      rd_buf_d    = rd_buf_q;
      cnt_d       = cnt_q;
      err_d       = 1'b0;
      stallreq_o  = NoStop;
      cpu_rdata_o = '0;
      case (state_q)
         IDLE: begin
            if (cpu_ce_i && !flush_i) begin
               stallreq_o = Stop;
               state_d    = BUSY;
               cyc_d      = 1'b1;
               we_d       = cpu_we_i;
               addr_d     = cpu_addr_i;
               sel_d      = cpu_sel_i;
               wdata_d    = cpu_wdata_i;
               cnt_d      = '0;
            end
         end
         BUSY: begin
            // flush beats ack, ack beats timeout
            if (flush_i || bus.ack || cnt_q >= cnt_last) begin
               state_d = (ack_ok && hold) ? WAIT_FOR_STALL : IDLE;
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               sel_d   = '0;
               err_d   = !flush_i && !bus.ack;
               if (ack_ok) begin
                  rd_buf_d    = bus.rdata;
                  cpu_rdata_o = bus.rdata;
               end
            end else begin
               stallreq_o = Stop;
               cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            end
         end
         WAIT_FOR_STALL: begin
            cpu_rdata_o = rd_buf_q;
            state_d     = (flush_i || !hold) ? IDLE : WAIT_FOR_STALL;
         end
         default: state_d = IDLE;
      endcase
      if (rst == RstEnable) begin
         stallreq_o  = NoStop;
         cpu_rdata_o = '0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q  <= IDLE;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         sel_q    <= '0;
         wdata_q  <= '0;
         rd_buf_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         err_q    <= err_d;
         addr_q   <= addr_d;
         sel_q    <= sel_d;
         wdata_q  <= wdata_d;
         rd_buf_q <= rd_buf_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if: directed bench for mem_bus_if with a read-data scoreboard.
module tb_mem_bus_if;
   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush, cpu_ce, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic [3:0]  cpu_sel;
   logic        stallreq;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] sb[$];
   mem_bus_if_if bus ();
   mem_bus_if #(.TIMEOUT_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (stall),
      .flush_i     (flush),
      .cpu_ce_i    (cpu_ce),
      .cpu_we_i    (cpu_we),
      .cpu_addr_i  (cpu_addr),
      .cpu_sel_i   (cpu_sel),
      .cpu_wdata_i (cpu_wdata),
      .cpu_rdata_o (cpu_rdata),
      .stallreq_o  (stallreq),
      .bus         (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask
   task automatic sb_chk(input string tag);
      logic [31:0] e;
      e = 32'hxxxxxxxx;
      if (sb.size() != 0) e = sb.pop_front();
      chk(tag, cpu_rdata, e);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic settle();
      #2;
   endtask
   task automatic req(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      cpu_ce    = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_sel   = s;
      cpu_wdata = d;
   endtask
   initial begin
      rst = 1'b1;
      stall = '0;
      flush = 1'b0;
      req(1'b0, 32'h100, 4'hF, 32'h0);
      bus.ack = 1'b0;
      bus.rdata = '0;
      tick();
      tick();
      settle();
      chk("rst_stallreq", {31'b0, stallreq}, 32'h0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      chk("rst_ctrl", {28'b0, bus.cyc, bus.stb, bus.we, bus.err}, 32'h0);
      chk("rst_addr", bus.addr, 32'h0);
      chk("rst_sel_wdata", bus.wdata | {28'b0, bus.sel}, 32'h0);
      // plain read, ack on third BUSY cycle
      tick();
      rst = 1'b0;
      sb.push_back(32'hDEADBEEF);
      settle();
      chk("rd_req_stallreq", {31'b0, stallreq}, 32'h1);
      chk("rd_req_cyc", {31'b0, bus.cyc}, 32'h0);
      tick();
      settle();
      chk("rd_b1_cycstb", {30'b0, bus.cyc, bus.stb}, 32'h3);
      chk("rd_b1_addr", bus.addr, 32'h100);
      chk("rd_b1_stallreq", {31'b0, stallreq}, 32'h1);
      chk("rd_b1_rdata", cpu_rdata, 32'h0);
      tick();
      settle();
      chk("rd_b2_stallreq", {31'b0, stallreq}, 32'h1);
      tick();
      bus.ack = 1'b1;
      bus.rdata = 32'hDEADBEEF;
      settle();
      chk("rd_ack_stallreq", {31'b0, stallreq}, 32'h0);
      sb_chk("rd_ack_rdata");
      tick();
      bus.ack = 1'b0;
      cpu_ce = 1'b0;
      settle();
      chk("rd_idle_cycstb", {30'b0, bus.cyc, bus.stb}, 32'h0);
      chk("rd_idle_stallreq", {31'b0, stallreq}, 32'h0);
      chk("rd_idle_rdata", cpu_rdata, 32'h0);
      // read acked while memory stage is held
      tick();
      stall = 6'b011111;
      req(1'b0, 32'h200, 4'hF, 32'h0);
      sb.push_back(32'h12345678);
      settle();
      chk("wfs_req_stallreq", {31'b0, stallreq}, 32'h1);
      tick();
      bus.ack = 1'b1;
      bus.rdata = 32'h12345678;
      settle();
      sb_chk("wfs_ack_rdata");
      chk("wfs_ack_stallreq", {31'b0, stallreq}, 32'h0);
      for (int i = 0; i < 2; i++) begin
         tick();
         bus.ack = 1'b0;
         bus.rdata = 32'hFFFFFFFF;
         settle();
         chk("wfs_hold_rdata", cpu_rdata, 32'h12345678);
         chk("wfs_hold_cyc", {31'b0, bus.cyc}, 32'h0);
         chk("wfs_hold_stallreq", {31'b0, stallreq}, 32'h0);
      end
      tick();
      stall = '0;
      settle();
      chk("wfs_release_rdata", cpu_rdata, 32'h12345678);
      tick();
      cpu_ce = 1'b0;
      settle();
      chk("wfs_idle_rdata", cpu_rdata, 32'h0);
      chk("wfs_idle_cyc", {31'b0, bus.cyc}, 32'h0);
      // write, bus fields must ignore later CPU changes
      tick();
      req(1'b1, 32'h80000010, 4'b0011, 32'h0000A5A5);
      sb.push_back(32'h0BADF00D);
      settle();
      chk("wr_req_stallreq", {31'b0, stallreq}, 32'h1);
      for (int i = 0; i < 2; i++) begin
         tick();
         req(1'b0, 32'h0, 4'h0, 32'h0);
         settle();
         chk("wr_busy_ctrl", {29'b0, bus.cyc, bus.stb, bus.we}, 32'h7);
         chk("wr_busy_addr", bus.addr, 32'h80000010);
         chk("wr_busy_sel", {28'b0, bus.sel}, 32'h3);
         chk("wr_busy_wdata", bus.wdata, 32'h0000A5A5);
      end
      tick();
      bus.ack = 1'b1;
      bus.rdata = 32'h0BADF00D;
      settle();
      chk("wr_ack_addr", bus.addr, 32'h80000010);
      sb_chk("wr_ack_rdata");
      tick();
      bus.ack = 1'b0;
      cpu_ce = 1'b0;
      settle();
      chk("wr_done_ctrl", {29'b0, bus.cyc, bus.stb, bus.we}, 32'h0);
      chk("wr_done_sel", {28'b0, bus.sel}, 32'h0);
      // timeout after four BUSY cycles
      tick();
      req(1'b0, 32'h300, 4'hF, 32'h0);
      settle();
      for (int i = 0; i < 3; i++) begin
         tick();
         settle();
         chk("to_busy_stallreq", {31'b0, stallreq}, 32'h1);
         chk("to_busy_err", {31'b0, bus.err}, 32'h0);
      end
      tick();
      settle();
      chk("to_last_stallreq", {31'b0, stallreq}, 32'h0);
      chk("to_last_cyc", {31'b0, bus.cyc}, 32'h1);
      tick();
      cpu_ce = 1'b0;
      settle();
      chk("to_err_pulse", {31'b0, bus.err}, 32'h1);
      chk("to_err_cyc", {31'b0, bus.cyc}, 32'h0);
      chk("to_err_stallreq", {31'b0, stallreq}, 32'h0);
      tick();
      settle();
      chk("to_err_single", {31'b0, bus.err}, 32'h0);
      // ack on the timeout cycle wins
      tick();
      req(1'b0, 32'h400, 4'hF, 32'h0);
      sb.push_back(32'h55AA55AA);
      settle();
      for (int i = 0; i < 3; i++) begin
         tick();
         settle();
         chk("edge_busy_stallreq", {31'b0, stallreq}, 32'h1);
      end
      tick();
      bus.ack = 1'b1;
      bus.rdata = 32'h55AA55AA;
      settle();
      chk("edge_ack_stallreq", {31'b0, stallreq}, 32'h0);
      sb_chk("edge_ack_rdata");
      tick();
      bus.ack = 1'b0;
      cpu_ce = 1'b0;
      settle();
      chk("edge_no_err", {31'b0, bus.err}, 32'h0);
      chk("edge_cyc", {31'b0, bus.cyc}, 32'h0);
      // flush together with ack, stage held so an accepted ack would show in WAIT_FOR_STALL
      tick();
      stall = 6'b011111;
      req(1'b0, 32'h500, 4'hF, 32'h0);
      settle();
      chk("fl_req_stallreq", {31'b0, stallreq}, 32'h1);
      tick();
      bus.ack = 1'b1;
      bus.rdata = 32'hCAFEF00D;
      flush = 1'b1;
      settle();
      chk("fl_ack_stallreq", {31'b0, stallreq}, 32'h0);
      tick();
      bus.ack = 1'b0;
      flush = 1'b0;
      cpu_ce = 1'b0;
      settle();
      chk("fl_after_cyc", {31'b0, bus.cyc}, 32'h0);
      chk("fl_after_rdata", cpu_rdata, 32'h0);
      tick();
      stall = '0;
      cpu_ce = 1'b1;
      flush = 1'b1;
      settle();
      chk("fl_idle_stallreq", {31'b0, stallreq}, 32'h0);
      tick();
      cpu_ce = 1'b0;
      flush = 1'b0;
      settle();
      chk("fl_idle_cyc", {31'b0, bus.cyc}, 32'h0);
      // reset mid-access
      tick();
      req(1'b1, 32'h600, 4'hF, 32'h1234);
      settle();
      tick();
      settle();
      chk("rb_busy_cyc", {31'b0, bus.cyc}, 32'h1);
      tick();
      rst = 1'b1;
      settle();
      chk("rb_rst_stallreq", {31'b0, stallreq}, 32'h0);
      chk("rb_rst_rdata", cpu_rdata, 32'h0);
      tick();
      rst = 1'b0;
      cpu_ce = 1'b0;
      settle();
      chk("rb_ctrl", {28'b0, bus.cyc, bus.stb, bus.we, bus.err}, 32'h0);
      chk("rb_addr", bus.addr, 32'h0);
      chk("rb_wdata", bus.wdata, 32'h0);
      chk("rb_sel", {28'b0, bus.sel}, 32'h0);
      tick();
      settle();
      chk("rb_no_err", {31'b0, bus.err}, 32'h0);
      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
